stack_unit: RTL and testbench

//   LIFO operand stack that serves the multicycle processor core. It consumes the

---
 rtl/stack_unit.sv | 112 +++++++++++
 tb/tb_stack_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/stack_unit.sv
// LIFO operand stack for the multicycle core: registered pop data, sticky
// overflow/underflow flags and a combinational peek port for debug.
module stack_unit #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  err_clear,
    input  logic [ADDR_WIDTH-1:0] peek_idx,
    output logic [DATA_WIDTH-1:0] peek_data,
    output logic                  peek_valid
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] CNT_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH:0]   count_nxt;
    logic [ADDR_WIDTH:0]   count_dec;
    logic [ADDR_WIDTH-1:0] top_idx;
    logic [DATA_WIDTH-1:0] data_nxt;
    logic                  overflow_nxt;
    logic                  underflow_nxt;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;

    assign full      = (count == CNT_FULL);
    assign empty     = (count == '0);
    assign count_dec = count - CNT_ONE;
    // Only meaningful when not empty; at count==DEPTH the truncation gives DEPTH-1.
    assign top_idx   = count_dec[ADDR_WIDTH-1:0];

    assign peek_data  = mem[top_idx - peek_idx];
    assign peek_valid = ({1'b0, peek_idx} < count);

    always_comb begin
        count_nxt     = count;
        data_nxt      = data_out;
        overflow_nxt  = overflow & ~err_clear;
        underflow_nxt = underflow & ~err_clear;
        wr_en         = 1'b0;
        wr_addr       = count[ADDR_WIDTH-1:0];

        case ({push, pop})
            2'b10: begin
                if (!full) begin
                    wr_en     = 1'b1;
                    wr_addr   = count[ADDR_WIDTH-1:0];
                    count_nxt = count + CNT_ONE;
                end else begin
                    overflow_nxt = 1'b1;
                end
            end
            2'b01: begin
                if (!empty) begin
                    data_nxt  = mem[top_idx];
                    count_nxt = count_dec;
                end else begin
                    underflow_nxt = 1'b1;
                end
            end
            2'b11: begin
                // Replace-top never overflows; on an empty stack it degrades to a push.
                if (!empty) begin
                    data_nxt = mem[top_idx];
                    wr_en    = 1'b1;
                    wr_addr  = top_idx;
                end else begin
                    wr_en         = 1'b1;
                    wr_addr       = '0;
                    count_nxt     = CNT_ONE;
                    underflow_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            count     <= '0;
            data_out  <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count     <= count_nxt;
            data_out  <= data_nxt;
            overflow  <= overflow_nxt;
            underflow <= underflow_nxt;
        end
    end

    // Storage is deliberately not reset; a write in a reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (resetN && wr_en) begin
            mem[wr_addr] <= data_in;
        end
    end

endmodule

// File: tb/tb_stack_unit.sv
// Directed bench for stack_unit: push/pop ordering, full/empty boundaries,
// sticky flags, replace-top, peek and reset-over-push.
module tb_stack_unit;

    logic       clk = 1'b0;
    logic       resetN;
    logic       push;
    logic       pop;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;
    logic       err_clear;
    logic [3:0] peek_idx;
    logic [7:0] peek_data;
    logic       peek_valid;

    int n_cmp = 0;
    int n_mis = 0;

    stack_unit #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk(clk), .resetN(resetN), .push(push), .pop(pop),
        .data_in(data_in), .data_out(data_out), .full(full), .empty(empty),
        .count(count), .overflow(overflow), .underflow(underflow),
        .err_clear(err_clear), .peek_idx(peek_idx), .peek_data(peek_data),
        .peek_valid(peek_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock with the given controls; sampling happens 1 time unit after the edge.
    task automatic step(input logic ps, input logic pp, input logic [7:0] d, input logic ec);
        push      = ps;
        pop       = pp;
        data_in   = d;
        err_clear = ec;
        @(posedge clk);
        #1;
        push      = 1'b0;
        pop       = 1'b0;
        err_clear = 1'b0;
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        step(1'b0, 1'b0, 8'h00, 1'b0);
        resetN = 1'b1;
    endtask

    initial begin
        resetN = 1'b0; push = 1'b0; pop = 1'b0; data_in = 8'h00;
        err_clear = 1'b0; peek_idx = 4'd0;
        #2;
        do_reset();

        chk("rst_count", 32'(count), 32'd0);
        chk("rst_data", 32'(data_out), 32'h00);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_unf", 32'(underflow), 32'd0);

        // basic LIFO order
        step(1'b1, 1'b0, 8'h11, 1'b0);
        step(1'b1, 1'b0, 8'h22, 1'b0);
        step(1'b1, 1'b0, 8'h33, 1'b0);
        chk("t1_count3", 32'(count), 32'd3);
        chk("t1_notempty", 32'(empty), 32'd0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        chk("t1_pop33", 32'(data_out), 32'h33);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        chk("t1_pop22", 32'(data_out), 32'h22);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        chk("t1_pop11", 32'(data_out), 32'h11);
        chk("t1_empty", 32'(empty), 32'd1);
        chk("t1_count0", 32'(count), 32'd0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("t1_hold", 32'(data_out), 32'h11);

        // fill, overflow, replace-top while full
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 8'(i), 1'b0);
            if (i == 14) chk("t2_notfull15", 32'(full), 32'd0);
        end
        chk("t2_full", 32'(full), 32'd1);
        chk("t2_count16", 32'(count), 32'd16);
        chk("t2_ovf_pre", 32'(overflow), 32'd0);
        step(1'b1, 1'b0, 8'hAA, 1'b0);
        chk("t2_ovf", 32'(overflow), 32'd1);
        chk("t2_count_sat", 32'(count), 32'd16);
        peek_idx = 4'd0; #1;
        chk("t2_peek_top", 32'(peek_data), 32'h0F);
        peek_idx = 4'd15; #1;
        chk("t2_peek_bot", 32'(peek_data), 32'h00);
        chk("t2_peek_bot_v", 32'(peek_valid), 32'd1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("t2_ovf_clr", 32'(overflow), 32'd0);
        step(1'b1, 1'b1, 8'h55, 1'b0);
        chk("t2_rt_data", 32'(data_out), 32'h0F);
        chk("t2_rt_noovf", 32'(overflow), 32'd0);
        chk("t2_rt_count", 32'(count), 32'd16);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        chk("t2_pop55", 32'(data_out), 32'h55);
        chk("t2_count15", 32'(count), 32'd15);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        chk("t2_pop0E", 32'(data_out), 32'h0E);

        // underflow and sticky clear
        do_reset();
        step(1'b0, 1'b1, 8'h00, 1'b0);
        chk("t3_unf", 32'(underflow), 32'd1);
        chk("t3_data_hold", 32'(data_out), 32'h00);
        chk("t3_count0", 32'(count), 32'd0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("t3_unf_sticky", 32'(underflow), 32'd1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("t3_unf_clr", 32'(underflow), 32'd0);
        step(1'b0, 1'b1, 8'h00, 1'b1);
        chk("t3_unf_wins", 32'(underflow), 32'd1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b1, 8'h66, 1'b0);
        chk("t3_pp_empty_cnt", 32'(count), 32'd1);
        chk("t3_pp_empty_unf", 32'(underflow), 32'd1);
        chk("t3_pp_empty_dh", 32'(data_out), 32'h00);
        step(1'b0, 1'b1, 8'h00, 1'b1);
        chk("t3_pop66", 32'(data_out), 32'h66);
        chk("t3_clr_after", 32'(underflow), 32'd0);

        // replace top
        step(1'b1, 1'b0, 8'h05, 1'b0);
        step(1'b1, 1'b0, 8'h07, 1'b0);
        step(1'b1, 1'b1, 8'h09, 1'b0);
        chk("t4_rt_data", 32'(data_out), 32'h07);
        chk("t4_rt_count", 32'(count), 32'd2);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        chk("t4_pop09", 32'(data_out), 32'h09);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        chk("t4_pop05", 32'(data_out), 32'h05);
        chk("t4_empty", 32'(empty), 32'd1);

        // peek
        do_reset();
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 8'(i), 1'b0);
        peek_idx = 4'd0; #1;
        chk("t5_peek0", 32'(peek_data), 32'h04);
        chk("t5_valid0", 32'(peek_valid), 32'd1);
        peek_idx = 4'd3; #1;
        chk("t5_peek3", 32'(peek_data), 32'h01);
        chk("t5_valid3", 32'(peek_valid), 32'd1);
        peek_idx = 4'd4; #1;
        chk("t5_valid4", 32'(peek_valid), 32'd0);
        peek_idx = 4'd1; #1;
        chk("t5_peek1", 32'(peek_data), 32'h03);
        chk("t5_count4", 32'(count), 32'd4);

        // reset overrides a simultaneous push
        do_reset();
        step(1'b1, 1'b0, 8'hA1, 1'b0);
        step(1'b1, 1'b0, 8'hA2, 1'b0);
        step(1'b1, 1'b0, 8'hA3, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        chk("t6_pre_unf", 32'(underflow), 32'd1);
        step(1'b1, 1'b0, 8'hB1, 1'b0);
        resetN = 1'b0;
        step(1'b1, 1'b0, 8'hBB, 1'b0);
        resetN = 1'b1;
        chk("t6_count0", 32'(count), 32'd0);
        chk("t6_data0", 32'(data_out), 32'h00);
        chk("t6_ovf0", 32'(overflow), 32'd0);
        chk("t6_unf0", 32'(underflow), 32'd0);
        chk("t6_empty", 32'(empty), 32'd1);
        step(1'b1, 1'b0, 8'hCC, 1'b0);
        peek_idx = 4'd0; #1;
        chk("t6_count1", 32'(count), 32'd1);
        chk("t6_peek_cc", 32'(peek_data), 32'hCC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
